// File: rtl/packed_cost_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : packed_cost_shift_reg
// Brief    : Right-pixel shift window producing DISP packed absolute-difference
//            matching costs per accepted left/right pixel pair.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module packed_cost_shift_reg #(
  parameter int PIX_W  = 8,
  parameter int DISP   = 4,
  parameter int COST_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sol,
  input  logic [PIX_W-1:0]         in_left,
  input  logic [PIX_W-1:0]         in_right,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DISP*COST_W-1:0]   out_cost,
  output logic [DISP*PIX_W-1:0]    out_win,
  output logic                     out_full
);

  localparam int                  C_FILL_W   = $clog2(DISP + 1);
  localparam logic [C_FILL_W-1:0] C_FILL_MAX = C_FILL_W'(DISP);
  localparam logic [C_FILL_W-1:0] C_FILL_ONE = C_FILL_W'(1);

  // The published window doubles as the shift state: both only change on accept.
  logic [DISP*PIX_W-1:0]  r_win;
  logic [C_FILL_W-1:0]    r_fill;
  logic [DISP*COST_W-1:0] r_out_cost;
  logic                   r_out_valid;
  logic                   r_out_full;

  logic                   w_accept;
  logic [C_FILL_W-1:0]    w_fill_nxt;
  logic [DISP*PIX_W-1:0]  w_win_nxt;
  logic [DISP*COST_W-1:0] w_cost_nxt;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_cost  = r_out_cost;
  assign out_win   = r_win;
  assign out_full  = r_out_full;

  always_comb begin
    w_fill_nxt = r_fill + 1'b1;
    if (in_sol) begin
      w_fill_nxt = C_FILL_ONE;
    end else if (r_fill == C_FILL_MAX) begin
      w_fill_nxt = C_FILL_MAX;
    end
  end

  generate
    for (genvar d = 0; d < DISP; d++) begin : g_lane
      localparam logic [C_FILL_W-1:0] C_LANE = C_FILL_W'(d);
      logic [PIX_W-1:0] w_pix;
      logic [PIX_W-1:0] w_diff;

      if (d == 0) begin : g_head
        assign w_pix = in_right;
      end else begin : g_tail
        assign w_pix = in_sol ? '0 : r_win[(d-1)*PIX_W +: PIX_W];
      end

      assign w_diff = (in_left >= w_pix) ? (in_left - w_pix) : (w_pix - in_left);
      assign w_win_nxt[d*PIX_W +: PIX_W] = w_pix;
      // Lanes not yet backed by a real pixel report the maximum cost.
      assign w_cost_nxt[d*COST_W +: COST_W] = (C_LANE < w_fill_nxt) ? COST_W'(w_diff) : '1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_fill      <= '0;
      r_out_cost  <= '0;
      r_out_valid <= 1'b0;
      r_out_full  <= 1'b0;
    end else if (w_accept) begin
      r_win       <= w_win_nxt;
      r_fill      <= w_fill_nxt;
      r_out_cost  <= w_cost_nxt;
      r_out_valid <= 1'b1;
      r_out_full  <= (w_fill_nxt == C_FILL_MAX);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packed_cost_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_packed_cost_shift_reg
// Brief    : Directed self-checking bench for packed_cost_shift_reg (8/4/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packed_cost_shift_reg;

  localparam int PIX_W  = 8;
  localparam int DISP   = 4;
  localparam int COST_W = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sol;
  logic [PIX_W-1:0]       in_left;
  logic [PIX_W-1:0]       in_right;
  logic                   out_valid;
  logic                   out_ready;
  logic [DISP*COST_W-1:0] out_cost;
  logic [DISP*PIX_W-1:0]  out_win;
  logic                   out_full;

  int n_checks = 0;
  int n_pass   = 0;

  packed_cost_shift_reg #(
    .PIX_W  (PIX_W),
    .DISP   (DISP),
    .COST_W (COST_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sol    (in_sol),
    .in_left   (in_left),
    .in_right  (in_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cost  (out_cost),
    .out_win   (out_win),
    .out_full  (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sol, input logic [7:0] left, input logic [7:0] right);
    in_valid = 1'b1;
    in_sol   = sol;
    in_left  = left;
    in_right = right;
    step();
  endtask

  task automatic check_out(input string tag, input logic [31:0] cost,
                           input logic [31:0] win, input logic full);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".cost"},  64'(out_cost),  64'(cost));
    check({tag, ".win"},   64'(out_win),   64'(win));
    check({tag, ".full"},  64'(out_full),  64'(full));
  endtask

  logic [31:0] sat_cost [1:10];
  logic [31:0] sat_win  [1:10];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sol    = 1'b0;
    in_left   = '0;
    in_right  = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.cost",  64'(out_cost),  64'd0);
    check("rst.win",   64'(out_win),   64'd0);
    check("rst.full",  64'(out_full),  64'd0);
    check("rst.ready", 64'(in_ready),  64'd1);
    rst_n = 1'b1;
    step();
    check("rel.ready", 64'(in_ready),  64'd1);

    // Single SOL beat
    beat(1'b1, 8'd10, 8'd7);
    in_valid = 1'b0;
    check_out("sol1", 32'hFFFFFF03, 32'h00000007, 1'b0);
    step();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Line fill, back to back
    beat(1'b1, 8'd45, 8'd20);
    check_out("fill1", 32'hFFFFFF19, 32'h00000014, 1'b0);
    beat(1'b0, 8'd45, 8'd30);
    check_out("fill2", 32'hFFFF190F, 32'h0000141E, 1'b0);
    beat(1'b0, 8'd45, 8'd40);
    check_out("fill3", 32'hFF190F05, 32'h00141E28, 1'b0);
    beat(1'b0, 8'd45, 8'd50);
    check_out("fill4", 32'h190F0505, 32'h141E2832, 1'b1);

    // Backpressure: pending beat must not be taken while stalled
    out_ready = 1'b0;
    in_right  = 8'd60;
    #1;
    check("bp.ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("bp.hold", 32'h190F0505, 32'h141E2832, 1'b1);
      check("bp.ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.ready1", 64'(in_ready), 64'd1);
    step();
    check_out("bp.take", 32'h0F05050F, 32'h1E28323C, 1'b1);

    // Mid-line SOL, drained and replaced in the same edge
    beat(1'b1, 8'd100, 8'd99);
    check_out("msol", 32'hFFFFFF01, 32'h00000063, 1'b0);

    // Saturating fill over 10 beats without SOL
    sat_cost[1] = 32'hFFFF6300; sat_win[1] = 32'h00006300;
    sat_cost[2] = 32'hFF630000; sat_win[2] = 32'h00630000;
    sat_cost[3] = 32'h63000000; sat_win[3] = 32'h63000000;
    for (int i = 4; i <= 9; i++) begin
      sat_cost[i] = 32'h00000000;
      sat_win[i]  = 32'h00000000;
    end
    sat_cost[10] = 32'hFFFFFFFF; sat_win[10] = 32'h00000000;
    for (int i = 1; i <= 10; i++) begin
      beat(1'b0, (i == 10) ? 8'd255 : 8'd0, 8'd0);
      check_out($sformatf("sat%0d", i), sat_cost[i], sat_win[i], (i >= 3));
    end

    // SOL without valid is ignored
    in_valid = 1'b0;
    in_sol   = 1'b1;
    step();
    check("solnv.valid", 64'(out_valid), 64'd0);
    beat(1'b0, 8'd7, 8'd7);
    check_out("solnv", 32'h07070700, 32'h00000007, 1'b1);

    // Asynchronous reset between edges with a pending result
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    check("pend.valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.cost",  64'(out_cost),  64'd0);
    check("arst.win",   64'(out_win),   64'd0);
    check("arst.full",  64'(out_full),  64'd0);
    check("arst.ready", 64'(in_ready),  64'd1);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_sol    = 1'b1;
    step();
    check("post.valid", 64'(out_valid), 64'd0);

    // First beat after reset without SOL starts a line
    beat(1'b0, 8'd8, 8'd5);
    in_valid = 1'b0;
    check_out("first", 32'hFFFFFF03, 32'h00000005, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
